vga_sprite_compositor: RTL and testbench
========================================

Name: vga_sprite_compositor

Overview:
Parametrised, pipelined successor to the single-cycle screen-picture mux. Composites NUM_SPRITES rectangular tiled sprites over a background pixel stream. Sprite boxes are double-buffered so the game logic can update them mid-frame without tearing. Sits between the game-state logic and the VGA timing/output stage; drives one shared external sprite ROM by class.

Parameters:
NUM_SPRITES, 10, number of sprite slots; slot 0 has the highest priority.
X_W, 10, pixel x width.
Y_W, 9, pixel y width.
CLASS_W, 2, sprite class width; selects the ROM bank.
UNIT_SIZE, 30, tile edge in pixels; sprite image repeats every UNIT_SIZE in x and y.
ROM_LAT, 1, external ROM read latency in cycles (≥1).
COLOR_W, 12, RGB width.
TRANSPARENT_KEY, 12'h000, ROM colour treated as see-through.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
pix_x  in  X_W  current pixel x
pix_y  in  Y_W  current pixel y
pix_valid  in  1  active-video qualifier for pix_x/pix_y/bg_rgb
bg_rgb  in  COLOR_W  background colour aligned with pix_x/pix_y
frame_start  in  1  one-cycle pulse before the first pixel of a frame
wr_en  in  1  shadow-register write strobe
wr_idx  in  $clog2(NUM_SPRITES)  slot to write
wr_enable  in  1  slot visible flag
wr_class  in  CLASS_W  slot class
wr_left/wr_right  in  X_W  box x bounds, left inclusive, right exclusive
wr_up/wr_down  in  Y_W  box y bounds, up inclusive, down exclusive
rom_addr  out  $clog2(UNIT_SIZE*UNIT_SIZE)  tile address
rom_class  out  CLASS_W  ROM bank select
rom_data  in  COLOR_W  ROM output, ROM_LAT cycles after rom_addr
rgb_out  out  COLOR_W  composited pixel, RGB order
rgb_valid  out  1  rgb_out qualifier
hit_any  out  1  opaque or transparent sprite covered this pixel, aligned with rgb_out
hit_idx  out  $clog2(NUM_SPRITES)  winning slot, aligned with rgb_out

Behaviour:
- Reset: all shadow and active slots get enable=0 and zeroed bounds and class. rgb_out=0, rgb_valid=0, hit_any=0, hit_idx=0, rom_addr=0, rom_class=0. Pipeline valid bits are cleared.
- Shadow bank: when wr_en=1, the slot wr_idx is written on the clock edge. wr_idx ≥ NUM_SPRITES is ignored.
- Active bank: on frame_start=1, every shadow slot is copied to the active bank in the same edge.
  - If wr_en and frame_start coincide, the copy uses the pre-write shadow value. The write lands in the shadow bank only and becomes visible at the next frame_start.
- Stage 1 (edge 1 after input):
  - A slot hits when it is enabled, left ≤ x < right, and up ≤ y < down.
  - The lowest-index hit wins. A box with right ≤ left or down ≤ up never hits.
  - Registered: hit flag, index, rom_class.
  - rom_addr = ((x−left) mod UNIT_SIZE) + ((y−up) mod UNIT_SIZE)·UNIT_SIZE.
  - pix_valid and bg_rgb are delayed alongside.
  - With no hit, rom_addr=0 and rom_class=0.
- Stage 2 (edge 1+ROM_LAT): rom_data is valid. Hit, index, valid and bg are delayed through a ROM_LAT shift register.
- Output register (edge 2+ROM_LAT):
  - rgb_out = rom_data if hit and rom_data ≠ TRANSPARENT_KEY; otherwise bg.
  - If the delayed pix_valid=0, then rgb_out=0, rgb_valid=0 and hit_any=0.
- Total latency is fixed at 2+ROM_LAT cycles. The block runs at full throughput (1 pixel/cycle) with no stall.
- Transparent pixels of a higher-priority slot do not reveal lower-priority slots; they show the background. hit_any=1 for them.
- Reset mid-frame: the pipeline is flushed. Outputs read 0 until new pixels propagate. The active bank stays disabled until the first frame_start after reset.

Optional Feature:
Macro: VGA_SPRITE_COLLIDE_EN.
- With the macro defined:
  - Adds output collide (1 bit) and output collide_mask (NUM_SPRITES bits).
  - During a frame, any valid pixel where slot 0 hits and at least one other enabled slot k also hits sets an internal sticky bit k, based on box overlap rather than ROM data.
  - On frame_start, collide_mask takes the sticky bits, collide takes their OR, and the sticky bits are cleared in the same edge.
  - Both outputs reset to 0.
- Without the macro: neither port exists and no collision logic is generated.

Test Plan:
1. Reset, then frame_start, then sweep pixels with no writes → rgb_out equals bg_rgb delayed 2+ROM_LAT cycles, and hit_any=0 throughout.
2. Write slot 3 {en=1, left=100, right=160, up=50, down=110, class=2}, then frame_start → at (100,50) rom_addr=0 and rom_class=2; at (131,81) rom_addr=1+1·30=31; at (160,50) no hit.
3. Slots 1 and 4 overlap at (200,200) → hit_idx=1. Force rom_data=12'h000 there → rgb_out equals bg_rgb and hit_any=1.
4. Change slot 2 left from 300 to 320 mid-frame → pixel (305,y) still hits under the old box until the next frame_start, and misses after it.
5. wr_en and frame_start in the same cycle → the new value is not visible this frame and is visible next frame. Assert rst mid-line → rgb_valid=0 for 2+ROM_LAT cycles and all slots disabled.
6. With VGA_SPRITE_COLLIDE_EN: slot 0 box overlaps slot 5 box → after the next frame_start, collide=1 and collide_mask=10'b0000100000. The following frame has no overlap → collide=0.

Source files
------------

// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - pipelined tiled-sprite compositor over a background pixel stream
// Optional collision reporting is built when VGA_SPRITE_COLLIDE_EN is defined.
module vga_sprite_compositor #(
    parameter int                 NUM_SPRITES     = 10,
    parameter int                 X_W             = 10,
    parameter int                 Y_W             = 9,
    parameter int                 CLASS_W         = 2,
    parameter int                 UNIT_SIZE       = 30,
    parameter int                 ROM_LAT         = 1,
    parameter int                 COLOR_W         = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [X_W-1:0]                           pix_x,
    input  logic [Y_W-1:0]                           pix_y,
    input  logic                                     pix_valid,
    input  logic [COLOR_W-1:0]                       bg_rgb,
    input  logic                                     frame_start,
    input  logic                                     wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0]           wr_idx,
    input  logic                                     wr_enable,
    input  logic [CLASS_W-1:0]                       wr_class,
    input  logic [X_W-1:0]                           wr_left,
    input  logic [X_W-1:0]                           wr_right,
    input  logic [Y_W-1:0]                           wr_up,
    input  logic [Y_W-1:0]                           wr_down,
    output logic [$clog2(UNIT_SIZE*UNIT_SIZE)-1:0]   rom_addr,
    output logic [CLASS_W-1:0]                       rom_class,
    input  logic [COLOR_W-1:0]                       rom_data,
    output logic [COLOR_W-1:0]                       rgb_out,
    output logic                                     rgb_valid,
    output logic                                     hit_any,
    output logic [$clog2(NUM_SPRITES)-1:0]           hit_idx
`ifdef VGA_SPRITE_COLLIDE_EN
    ,
    output logic                                     collide,
    output logic [NUM_SPRITES-1:0]                   collide_mask
`endif
);
    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int AW    = $clog2(UNIT_SIZE*UNIT_SIZE);

    typedef struct packed {
        logic               en;
        logic [CLASS_W-1:0] cls;
        logic [X_W-1:0]     left;
        logic [X_W-1:0]     right;
        logic [Y_W-1:0]     up;
        logic [Y_W-1:0]     down;
    } slot_t;

    slot_t sh_q  [NUM_SPRITES];
    slot_t act_q [NUM_SPRITES];
    slot_t wr_slot;

    assign wr_slot = '{en: wr_enable, cls: wr_class, left: wr_left, right: wr_right,
                       up: wr_up, down: wr_down};

    // Active bank copies the pre-write shadow value when a write coincides with frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (frame_start)
                    act_q[i] <= sh_q[i];
                if (wr_en && wr_idx == IDX_W'(i))
                    sh_q[i] <= wr_slot;
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_vec;
    logic                   hit_d;
    logic [IDX_W-1:0]       idx_d;
    logic [X_W-1:0]         sel_left, dx;
    logic [Y_W-1:0]         sel_up, dy;
    logic [CLASS_W-1:0]     sel_cls, class_d;
    logic [AW-1:0]          addr_d;

    always_comb begin
        hit_vec  = '0;
        idx_d    = '0;
        sel_left = '0;
        sel_up   = '0;
        sel_cls  = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            hit_vec[i] = act_q[i].en && pix_x >= act_q[i].left && pix_x < act_q[i].right
                         && pix_y >= act_q[i].up && pix_y < act_q[i].down;
        // Walk downward so the lowest-index hit is the last one assigned.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                idx_d    = IDX_W'(i);
                sel_left = act_q[i].left;
                sel_up   = act_q[i].up;
                sel_cls  = act_q[i].cls;
            end
        end
        hit_d   = |hit_vec;
        dx      = pix_x - sel_left;
        dy      = pix_y - sel_up;
        addr_d  = hit_d ? AW'(dx % X_W'(UNIT_SIZE)) + AW'(dy % Y_W'(UNIT_SIZE)) * AW'(UNIT_SIZE)
                        : '0;
        class_d = hit_d ? sel_cls : '0;
    end

    logic               s1_hit_q, s1_valid_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [COLOR_W-1:0] s1_bg_q;
    logic [AW-1:0]      rom_addr_q;
    logic [CLASS_W-1:0] rom_class_q;
    logic               dl_hit_q   [ROM_LAT];
    logic               dl_valid_q [ROM_LAT];
    logic [IDX_W-1:0]   dl_idx_q   [ROM_LAT];
    logic [COLOR_W-1:0] dl_bg_q    [ROM_LAT];
    logic [COLOR_W-1:0] rgb_q;
    logic               rgb_valid_q, hit_any_q;
    logic [IDX_W-1:0]   hit_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_bg_q     <= '0;
            rom_addr_q  <= '0;
            rom_class_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_hit_q[i]   <= 1'b0;
                dl_valid_q[i] <= 1'b0;
                dl_idx_q[i]   <= '0;
                dl_bg_q[i]    <= '0;
            end
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            hit_any_q   <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            s1_hit_q    <= hit_d;
            s1_valid_q  <= pix_valid;
            s1_idx_q    <= idx_d;
            s1_bg_q     <= bg_rgb;
            rom_addr_q  <= addr_d;
            rom_class_q <= class_d;
            dl_hit_q[0]   <= s1_hit_q;
            dl_valid_q[0] <= s1_valid_q;
            dl_idx_q[0]   <= s1_idx_q;
            dl_bg_q[0]    <= s1_bg_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_hit_q[i]   <= dl_hit_q[i-1];
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_idx_q[i]   <= dl_idx_q[i-1];
                dl_bg_q[i]    <= dl_bg_q[i-1];
            end
            if (dl_valid_q[ROM_LAT-1]) begin
                rgb_q       <= (dl_hit_q[ROM_LAT-1] && rom_data != TRANSPARENT_KEY)
                               ? rom_data : dl_bg_q[ROM_LAT-1];
                rgb_valid_q <= 1'b1;
                hit_any_q   <= dl_hit_q[ROM_LAT-1];
                hit_idx_q   <= dl_idx_q[ROM_LAT-1];
            end else begin
                rgb_q       <= '0;
                rgb_valid_q <= 1'b0;
                hit_any_q   <= 1'b0;
                hit_idx_q   <= '0;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_class = rom_class_q;
    assign rgb_out   = rgb_q;
    assign rgb_valid = rgb_valid_q;
    assign hit_any   = hit_any_q;
    assign hit_idx   = hit_idx_q;

`ifdef VGA_SPRITE_COLLIDE_EN
    logic [NUM_SPRITES-1:0] sticky_q, collide_mask_q;
    logic                   collide_q;

    // Overlap is judged on box geometry only; slot 0 never flags itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q       <= '0;
            collide_mask_q <= '0;
            collide_q      <= 1'b0;
        end else if (frame_start) begin
            collide_mask_q <= sticky_q;
            collide_q      <= |sticky_q;
            sticky_q       <= '0;
        end else if (pix_valid && hit_vec[0]) begin
            sticky_q <= sticky_q | (hit_vec & ~NUM_SPRITES'(1));
        end
    end

    assign collide      = collide_q;
    assign collide_mask = collide_mask_q;
`endif
endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb/tb_vga_sprite_compositor.sv - randomized self-checking bench for vga_sprite_compositor
module tb_vga_sprite_compositor;
    localparam int N   = 10;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        pix_valid = 1'b0;
    logic [11:0] bg_rgb = '0;
    logic        frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic        wr_enable = 1'b0;
    logic [1:0]  wr_class = '0;
    logic [9:0]  wr_left = '0, wr_right = '0;
    logic [8:0]  wr_up = '0, wr_down = '0;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_class;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb_out;
    logic        rgb_valid, hit_any;
    logic [3:0]  hit_idx;
`ifdef VGA_SPRITE_COLLIDE_EN
    logic        collide;
    logic [N-1:0] collide_mask;
`endif

    vga_sprite_compositor dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .bg_rgb(bg_rgb), .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_enable(wr_enable), .wr_class(wr_class), .wr_left(wr_left), .wr_right(wr_right),
        .wr_up(wr_up), .wr_down(wr_down), .rom_addr(rom_addr), .rom_class(rom_class),
        .rom_data(rom_data), .rgb_out(rgb_out), .rgb_valid(rgb_valid), .hit_any(hit_any),
        .hit_idx(hit_idx)
`ifdef VGA_SPRITE_COLLIDE_EN
        , .collide(collide), .collide_mask(collide_mask)
`endif
    );

    always #5 clk = ~clk;

    bit force_zero = 1'b0;

    function automatic int rom_fn(input int cls, input int addr);
        if (addr % 7 == 3) return 0;
        return (cls << 10) | addr;
    endfunction

    always @(posedge clk)
        rom_data <= force_zero ? 12'h000 : 12'(rom_fn(int'(rom_class), int'(rom_addr)));

    typedef struct { bit en; int cls, l, r, u, d; } mslot_t;
    typedef struct { bit v; int rgb; bit hit; int idx; } mexp_t;

    mslot_t m_sh [N];
    mslot_t m_act[N];
    mexp_t  ex   [LAT];
    int     e_addr, e_cls;
    int     sticky, e_mask;
    int     n_vec = 0, n_err = 0;

    task automatic set_pix(input int x, input int y, input bit v);
        pix_x = 10'(x); pix_y = 9'(y); pix_valid = v; bg_rgb = 12'($urandom);
    endtask

    task automatic write_slot(input int idx, input bit en, input int cls,
                              input int l, input int r, input int u, input int d);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_enable = en; wr_class = 2'(cls);
        wr_left = 10'(l); wr_right = 10'(r); wr_up = 9'(u); wr_down = 9'(d);
    endtask

    // One clock: model evaluates the current inputs with pre-edge state, then the edge happens.
    task automatic tick();
        mexp_t ne;
        int w, col;
        bit [N-1:0] hv;
        ne = '{v: 0, rgb: 0, hit: 0, idx: 0};
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_sh[i]  = '{en: 0, cls: 0, l: 0, r: 0, u: 0, d: 0};
                m_act[i] = m_sh[i];
            end
            for (int k = 0; k < LAT; k++) ex[k] = ne;
            e_addr = 0; e_cls = 0; sticky = 0; e_mask = 0;
        end else begin
            w = -1; hv = '0; col = 0;
            for (int i = 0; i < N; i++) begin
                hv[i] = m_act[i].en && int'(pix_x) >= m_act[i].l && int'(pix_x) < m_act[i].r
                        && int'(pix_y) >= m_act[i].u && int'(pix_y) < m_act[i].d;
                if (hv[i] && w < 0) w = i;
            end
            if (w >= 0) begin
                e_addr = (int'(pix_x) - m_act[w].l) % 30 + ((int'(pix_y) - m_act[w].u) % 30) * 30;
                e_cls  = m_act[w].cls;
                col    = force_zero ? 0 : rom_fn(e_cls, e_addr);
            end else begin
                e_addr = 0; e_cls = 0;
            end
            if (pix_valid) begin
                ne.v   = 1;
                ne.hit = (w >= 0);
                ne.idx = (w >= 0) ? w : 0;
                ne.rgb = (w >= 0 && col != 0) ? col : int'(bg_rgb);
            end
            if (frame_start) begin
                e_mask = sticky; sticky = 0;
            end else if (pix_valid && hv[0]) begin
                for (int k = 1; k < N; k++) if (hv[k]) sticky |= (1 << k);
            end
            if (frame_start) for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            if (wr_en && int'(wr_idx) < N)
                m_sh[wr_idx] = '{en: wr_enable, cls: int'(wr_class), l: int'(wr_left),
                                 r: int'(wr_right), u: int'(wr_up), d: int'(wr_down)};
            for (int k = LAT - 1; k > 0; k--) ex[k] = ex[k-1];
            ex[0] = ne;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_pix(0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if ({rgb_out, rgb_valid, hit_any, hit_idx, rom_addr, rom_class} !== '0) begin
            n_err++;
            $display("FAIL reset_state: rgb=%h v=%b hit=%b idx=%0d addr=%0d cls=%0d, want all 0",
                     rgb_out, rgb_valid, hit_any, hit_idx, rom_addr, rom_class);
        end
        rst = 1'b0;
        idle(LAT);
    endtask

    task automatic test_background();
        frame_start = 1'b1;
        set_pix(0, 0, 0);
        tick();
        for (int i = 0; i < 40 + LAT; i++) begin
            set_pix($urandom_range(0, 639), $urandom_range(0, 479), i < 40);
            tick();
            n_vec++;
            if (rgb_valid !== ex[LAT-1].v || rgb_out !== 12'(ex[LAT-1].rgb) || hit_any !== 1'b0) begin
                n_err++;
                $display("FAIL bg_sweep: rgb=%h v=%b hit=%b, want rgb=%h v=%b hit=0",
                         rgb_out, rgb_valid, hit_any, ex[LAT-1].rgb, ex[LAT-1].v);
            end
        end
    endtask

    task automatic test_tile_addr();
        write_slot(3, 1, 2, 100, 160, 50, 110);
        set_pix(0, 0, 0);
        tick();
        frame_start = 1'b1;
        tick();
        set_pix(100, 50, 1); tick();
        n_vec++;
        if (rom_addr !== 10'd0 || rom_class !== 2'd2 || int'(rom_addr) != e_addr) begin
            n_err++;
            $display("FAIL tile_origin: addr=%0d cls=%0d, want addr=0 cls=2", rom_addr, rom_class);
        end
        set_pix(131, 81, 1); tick();
        n_vec++;
        if (rom_addr !== 10'd31 || rom_class !== 2'd2 || int'(rom_addr) != e_addr) begin
            n_err++;
            $display("FAIL tile_wrap: addr=%0d cls=%0d, want addr=31 cls=2", rom_addr, rom_class);
        end
        set_pix(160, 50, 1); tick();
        n_vec++;
        if (rom_addr !== 10'd0 || rom_class !== 2'd0) begin
            n_err++;
            $display("FAIL tile_right_edge: addr=%0d cls=%0d, want 0/0", rom_addr, rom_class);
        end
        for (int i = 0; i < 30 + LAT; i++) begin
            set_pix($urandom_range(90, 170), $urandom_range(40, 120), i < 30);
            tick();
            n_vec++;
            if (rgb_valid !== ex[LAT-1].v || rgb_out !== 12'(ex[LAT-1].rgb) ||
                hit_any !== ex[LAT-1].hit || hit_idx !== 4'(ex[LAT-1].idx)) begin
                n_err++;
                $display("FAIL tile_pixel: rgb=%h v=%b hit=%b idx=%0d, want rgb=%h v=%b hit=%b idx=%0d",
                         rgb_out, rgb_valid, hit_any, hit_idx, ex[LAT-1].rgb, ex[LAT-1].v,
                         ex[LAT-1].hit, ex[LAT-1].idx);
            end
        end
    endtask

    task automatic test_priority();
        write_slot(1, 1, 1, 180, 220, 180, 220); set_pix(0, 0, 0); tick();
        write_slot(4, 1, 3, 190, 260, 190, 260); tick();
        frame_start = 1'b1; tick();
        set_pix(200, 200, 1); tick(); idle(LAT - 1);
        n_vec++;
        if (hit_idx !== 4'd1 || hit_any !== 1'b1 || rgb_out !== 12'(ex[LAT-1].rgb)) begin
            n_err++;
            $display("FAIL priority: idx=%0d hit=%b rgb=%h, want idx=1 hit=1 rgb=%h",
                     hit_idx, hit_any, rgb_out, ex[LAT-1].rgb);
        end
        force_zero = 1'b1;
        set_pix(200, 200, 1); bg_rgb = 12'h5A5; tick(); idle(LAT - 1);
        n_vec++;
        if (rgb_out !== 12'h5A5 || hit_any !== 1'b1 || hit_idx !== 4'd1 || rgb_valid !== 1'b1) begin
            n_err++;
            $display("FAIL transparent_top: rgb=%h hit=%b idx=%0d, want rgb=5a5 hit=1 idx=1",
                     rgb_out, hit_any, hit_idx);
        end
        force_zero = 1'b0;
        idle(1);
    endtask

    task automatic test_shadow();
        write_slot(2, 1, 0, 300, 340, 0, 400); set_pix(0, 0, 0); tick();
        frame_start = 1'b1; tick();
        write_slot(2, 1, 0, 320, 340, 0, 400); tick();
        set_pix(305, 10, 1); tick(); idle(LAT - 1);
        n_vec++;
        if (hit_any !== 1'b1 || hit_idx !== 4'd2 || hit_any !== ex[LAT-1].hit) begin
            n_err++;
            $display("FAIL shadow_old_box: hit=%b idx=%0d, want hit=1 idx=2", hit_any, hit_idx);
        end
        frame_start = 1'b1; tick();
        set_pix(305, 10, 1); tick(); idle(LAT - 1);
        n_vec++;
        if (hit_any !== 1'b0 || rgb_valid !== 1'b1 || rgb_out !== 12'(ex[LAT-1].rgb)) begin
            n_err++;
            $display("FAIL shadow_new_box: hit=%b v=%b rgb=%h, want hit=0 v=1 rgb=%h",
                     hit_any, rgb_valid, rgb_out, ex[LAT-1].rgb);
        end
    endtask

    task automatic test_coincide();
        write_slot(6, 1, 1, 400, 450, 300, 350); frame_start = 1'b1; set_pix(0, 0, 0); tick();
        set_pix(410, 310, 1); tick(); idle(LAT - 1);
        n_vec++;
        if (hit_any !== 1'b0 || rgb_valid !== 1'b1) begin
            n_err++;
            $display("FAIL coincide_same_frame: hit=%b v=%b, want hit=0 v=1", hit_any, rgb_valid);
        end
        frame_start = 1'b1; tick();
        set_pix(410, 310, 1); tick(); idle(LAT - 1);
        n_vec++;
        if (hit_any !== 1'b1 || hit_idx !== 4'd6 || rgb_out !== 12'(ex[LAT-1].rgb)) begin
            n_err++;
            $display("FAIL coincide_next_frame: hit=%b idx=%0d rgb=%h, want hit=1 idx=6 rgb=%h",
                     hit_any, hit_idx, rgb_out, ex[LAT-1].rgb);
        end
    endtask

    task automatic test_random();
        int l, u;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                l = $urandom_range(0, 380); u = $urandom_range(0, 380);
                write_slot($urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                           l, l + $urandom_range(0, 90) - 10, u, u + $urandom_range(0, 90) - 10);
            end
            frame_start = ($urandom_range(0, 29) == 0);
            set_pix($urandom_range(0, 420), $urandom_range(0, 420), $urandom_range(0, 7) != 0);
            tick();
            n_vec++;
            if (rgb_valid !== ex[LAT-1].v || rgb_out !== 12'(ex[LAT-1].rgb) ||
                hit_any !== ex[LAT-1].hit || hit_idx !== 4'(ex[LAT-1].idx)) begin
                n_err++;
                $display("FAIL random_pixel: rgb=%h v=%b hit=%b idx=%0d, want rgb=%h v=%b hit=%b idx=%0d",
                         rgb_out, rgb_valid, hit_any, hit_idx, ex[LAT-1].rgb, ex[LAT-1].v,
                         ex[LAT-1].hit, ex[LAT-1].idx);
            end
`ifdef VGA_SPRITE_COLLIDE_EN
            n_vec++;
            if (collide_mask !== N'(e_mask) || collide !== (e_mask != 0)) begin
                n_err++;
                $display("FAIL random_collide: mask=%b c=%b, want mask=%b", collide_mask, collide,
                         N'(e_mask));
            end
`endif
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) begin set_pix(410, 310, 1); tick(); end
        rst = 1'b1; set_pix(410, 310, 1); tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            if (i == 1) frame_start = 1'b1;
            set_pix(410 + i, 310, 1);
            n_vec++;
            if ((i < LAT && rgb_valid !== 1'b0) || rgb_valid !== ex[LAT-1].v ||
                rgb_out !== 12'(ex[LAT-1].rgb) || hit_any !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flush[%0d]: v=%b rgb=%h hit=%b, want v=%b rgb=%h hit=0",
                         i, rgb_valid, rgb_out, hit_any, ex[LAT-1].v, ex[LAT-1].rgb);
            end
            tick();
        end
    endtask

`ifdef VGA_SPRITE_COLLIDE_EN
    task automatic test_collide();
        write_slot(0, 1, 0, 10, 50, 10, 50); set_pix(0, 0, 0); tick();
        write_slot(5, 1, 1, 30, 70, 30, 70); tick();
        frame_start = 1'b1; tick();
        set_pix(40, 40, 1); tick();
        set_pix(20, 20, 1); tick();
        write_slot(5, 1, 1, 200, 220, 200, 220); set_pix(0, 0, 0); tick();
        frame_start = 1'b1; tick();
        n_vec++;
        if (collide !== 1'b1 || collide_mask !== 10'b0000100000 || collide_mask !== N'(e_mask)) begin
            n_err++;
            $display("FAIL collide_set: c=%b mask=%b, want c=1 mask=0000100000", collide, collide_mask);
        end
        set_pix(40, 40, 1); tick();
        set_pix(0, 0, 0); frame_start = 1'b1; tick();
        n_vec++;
        if (collide !== 1'b0 || collide_mask !== '0) begin
            n_err++;
            $display("FAIL collide_clear: c=%b mask=%b, want 0", collide, collide_mask);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_background();
        test_tile_addr();
        test_priority();
        test_shadow();
        test_coincide();
        test_random();
        test_reset_midframe();
`ifdef VGA_SPRITE_COLLIDE_EN
        test_collide();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
